// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector with zero-latency Mealy match and saturating match counter
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0001_1011,
    parameter int RST_LEN = 5,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [MAX_LEN:0] MASK_ONE = 1;
    logic [MAX_LEN-1:0] history, pattern, window, mask;
    logic [MAX_LEN:0] mask_ext;
    logic [LEN_W-1:0] len;
    logic at_full;
    // window is the history as it would look with din appended; only the low len bits are compared
    assign window = {history[MAX_LEN-2:0], din};
    assign mask_ext = (MASK_ONE << len) - MASK_ONE;
    assign mask = mask_ext[MAX_LEN-1:0];
    assign at_full = (len != '0) && (fill == len - LEN_ONE);
    assign match = din_valid && !cfg_load && !rst && at_full && ((window & mask) == (pattern & mask));
    // configuration, history/fill tracking and saturating match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= RST_PATTERN;
            len <= LEN_W'(RST_LEN);
            history <= '0;
            fill <= '0;
            match_count <= '0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            history <= '0;
            fill <= '0;
            match_count <= '0;
        end else begin
            if (count_clr)
                match_count <= '0;
            else if (match && !(&match_count))
                match_count <= match_count + CNT_ONE;
            if (din_valid) begin
                if (match && !overlap) begin
                    history <= '0;
                    fill <= '0;
                end else begin
                    history <= window;
                    if (len != '0 && fill != len - LEN_ONE)
                        fill <= fill + LEN_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed spec scenarios plus randomized run against a bit-queue reference model
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst = 1'b0, din_valid = 1'b0, din = 1'b0, overlap = 1'b1, cfg_load = 1'b0, count_clr = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic match, match2;
    logic [7:0] match_count;
    logic [1:0] count2;
    logic [3:0] fill, fill2;
    int checks = 0, errors = 0;
    bit m_q[$];
    logic [7:0] m_pat;
    int m_len, m_cnt, m_cnt2;

    seq_detect_param dut (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .count_clr(count_clr),
        .match(match), .match_count(match_count), .fill(fill));
    seq_detect_param #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .count_clr(count_clr),
        .match(match2), .match_count(count2), .fill(fill2));

    always #5 clk = ~clk;

    // the last len bits received (oldest first, din last) must spell pattern[len-1] down to pattern[0]
    function automatic bit m_match();
        if (rst || cfg_load || !din_valid || m_len == 0 || m_q.size() < m_len - 1) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            bit w;
            w = (i == m_len - 1) ? din : m_q[m_q.size() - (m_len - 1) + i];
            if (w != m_pat[m_len - 1 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_fill();
        if (m_len == 0) return 0;
        return (m_q.size() < m_len - 1) ? m_q.size() : m_len - 1;
    endfunction

    task automatic tick();
        bit mt;
        mt = m_match();
        @(posedge clk);
        if (rst) begin
            m_pat = 8'b0001_1011; m_len = 5; m_q.delete(); m_cnt = 0; m_cnt2 = 0;
        end else if (cfg_load) begin
            m_pat = cfg_pattern; m_len = (cfg_len > 8) ? 8 : int'(cfg_len); m_q.delete(); m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (count_clr) begin m_cnt = 0; m_cnt2 = 0; end
            else if (mt) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (din_valid) begin
                if (mt && !overlap) m_q.delete();
                else begin
                    m_q.push_back(din);
                    if (m_q.size() > 8) void'(m_q.pop_front());
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit d, input bit ov, input bit clr);
        @(negedge clk);
        din_valid = v; din = d; overlap = ov; count_clr = clr;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b1; din = 1'b1; cfg_load = 1'b1; count_clr = 1'b0;
        #2;
        checks++;
        if (match !== 1'b0) begin errors++; $display("FAIL rst_match got %b exp 0", match); end
        tick();
        rst = 1'b0; cfg_load = 1'b0; din_valid = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; din_valid = 1'b1; din = pat[0]; count_clr = 1'b0;
        #2;
        checks++;
        if (match !== 1'b0) begin errors++; $display("FAIL cfg_match got %b exp 0", match); end
        tick();
        cfg_load = 1'b0; din_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fill !== 4'd0 || match_count !== 8'd0)
            begin errors++; $display("FAIL reset_state fill %0d cnt %0d exp 0 0", fill, match_count); end
    endtask

    task automatic test_overlap();
        logic [7:0] bits = 8'b1101_1011, expm = 8'b0000_1001;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7 - i], 1'b1, 1'b0);
            checks++;
            if (match !== expm[7 - i]) begin errors++; $display("FAIL ov_match bit %0d got %b exp %b", i + 1, match, expm[7 - i]); end
            tick();
        end
        checks++;
        if (match_count !== 8'd2) begin errors++; $display("FAIL ov_count got %0d exp 2", match_count); end
    endtask

    task automatic test_no_overlap();
        logic [7:0] bits = 8'b1101_1011, expm = 8'b0000_1000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7 - i], 1'b0, 1'b0);
            checks++;
            if (match !== expm[7 - i]) begin errors++; $display("FAIL noov_match bit %0d got %b exp %b", i + 1, match, expm[7 - i]); end
            tick();
        end
        checks++;
        if (fill !== 4'd3 || match_count !== 8'd1)
            begin errors++; $display("FAIL noov_end fill %0d cnt %0d exp 3 1", fill, match_count); end
    endtask

    task automatic test_cfg3();
        logic [4:0] bits = 5'b10101, expm = 5'b00101;
        do_reset();
        cfg(8'b0000_0101, 4'd3);
        checks++;
        if (fill !== 4'd0 || match_count !== 8'd0)
            begin errors++; $display("FAIL cfg3_clear fill %0d cnt %0d exp 0 0", fill, match_count); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bits[4 - i], 1'b1, 1'b0);
            checks++;
            if (match !== expm[4 - i]) begin errors++; $display("FAIL cfg3_match bit %0d got %b exp %b", i + 1, match, expm[4 - i]); end
            tick();
        end
        checks++;
        if (match_count !== 8'd2) begin errors++; $display("FAIL cfg3_count got %0d exp 2", match_count); end
    endtask

    task automatic test_gap();
        logic [3:0] bits = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bits[3 - i], 1'b1, 1'b0);
            checks++;
            if (match !== 1'b0) begin errors++; $display("FAIL gap_pre bit %0d got %b exp 0", i + 1, match); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            checks++;
            if (match !== 1'b0 || fill !== 4'd4)
                begin errors++; $display("FAIL gap_hold cyc %0d match %b fill %0d exp 0 4", i, match, fill); end
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (match !== 1'b1) begin errors++; $display("FAIL gap_final got %b exp 1", match); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        cfg(8'h01, 4'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (match !== 1'b1 || fill !== 4'd0)
                begin errors++; $display("FAIL sat_match cyc %0d match %b fill %0d exp 1 0", i, match, fill); end
            tick();
        end
        checks++;
        if (count2 !== 2'd3 || match_count !== 8'd5)
            begin errors++; $display("FAIL sat_count cnt2 %0d cnt %0d exp 3 5", count2, match_count); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (match !== 1'b1) begin errors++; $display("FAIL sat_clr_match got %b exp 1", match); end
        tick();
        checks++;
        if (count2 !== 2'd0 || match_count !== 8'd0)
            begin errors++; $display("FAIL sat_clr cnt2 %0d cnt %0d exp 0 0", count2, match_count); end
    endtask

    task automatic test_len_bounds();
        logic [7:0] pat = 8'hA5;
        do_reset();
        cfg(8'h00, 4'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (match !== 1'b0 || fill !== 4'd0)
                begin errors++; $display("FAIL len0 cyc %0d match %b fill %0d exp 0 0", i, match, fill); end
            tick();
        end
        cfg(pat, 4'd12);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[7 - i], 1'b1, 1'b0);
            checks++;
            if (match !== (i == 7)) begin errors++; $display("FAIL len12 bit %0d got %b exp %b", i + 1, match, i == 7); end
            tick();
        end
        checks++;
        if (fill !== 4'd7) begin errors++; $display("FAIL len12_fill got %0d exp 7", fill); end
    endtask

    task automatic test_reset_mid();
        logic [4:0] bits = 5'b11011;
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1'b1, bits[4 - i], 1'b1, 1'b0); tick(); end
        do_reset();
        checks++;
        if (fill !== 4'd0) begin errors++; $display("FAIL rstmid_fill got %0d exp 0", fill); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bits[4 - i], 1'b1, 1'b0);
            checks++;
            if (match !== (i == 4)) begin errors++; $display("FAIL rstmid_match bit %0d got %b exp %b", i + 1, match, i == 4); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) do_reset();
            else if (r < 4) cfg(8'($urandom), (r == 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)));
            else begin
                drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
                checks++;
                if (match !== m_match() || fill !== 4'(m_fill()) || match_count !== 8'(m_cnt) || count2 !== 2'(m_cnt2))
                    begin errors++; $display("FAIL rand cyc %0d match %b fill %0d cnt %0d cnt2 %0d exp %b %0d %0d %0d", n, match, fill, match_count, count2, m_match(), m_fill(), m_cnt, m_cnt2); end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_cfg3();
        test_gap();
        test_saturate();
        test_len_bounds();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
